// File: rtl/custom_freq_gen.sv
// -----------------------------------------------------------------------------
// custom_freq_gen
//
// A bank of NUM_CH numerically controlled oscillators, plus a synchronised
// switch status register. All of it is programmed over an Avalon-MM slave that
// sits on the HPS lightweight bridge.
//
// Each channel owns a phase accumulator and two tuning words:
//   - a shadow word, which is what the CPU writes;
//   - an active word, which is what the accumulator adds.
// A new shadow value moves into the active word only at an accumulator wrap,
// so a running square wave never gets a shortened period. When the channel is
// disabled there is nothing to protect, so the new value moves across on the
// next cycle.
//
// Register map (word addresses):
//   0      CTRL    [NUM_CH-1:0] channel enable
//   1      STATUS  [SW_W-1:0]   synchronised sw (read-only)
//                  [16 +: SW_W] sticky change flags (write 1 to clear)
//                  [24 +: NUM_CH] update-pending flags (read-only)
//   2+ch   TUNE    [ACC_W-1:0]  shadow tuning word of channel ch
//   other          reads return 0, writes are ignored
//
// Ports:
//   clk, reset              system clock; synchronous active-high reset
//   avs_s0_*                Avalon-MM slave with read latency 1 and no waitrequest
//   sw                      asynchronous switch inputs
//   freq_out                per-channel square wave (accumulator MSB)
//   wrap_pulse              one-cycle pulse after each accumulator carry-out
// -----------------------------------------------------------------------------
module custom_freq_gen #(
  parameter int NUM_CH = 4,
  parameter int ACC_W  = 32,
  parameter int SW_W   = 4,
  parameter int ADDR_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   avs_s0_address,
  input  logic                avs_s0_read,
  input  logic                avs_s0_write,
  input  logic [31:0]         avs_s0_writedata,
  output logic [31:0]         avs_s0_readdata,
  output logic                avs_s0_readdatavalid,
  input  logic [SW_W-1:0]     sw,
  output logic [NUM_CH-1:0]   freq_out,
  output logic [NUM_CH-1:0]   wrap_pulse
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [NUM_CH-1:0]              r_ctrl;
  logic [SW_W-1:0]                r_sw_meta;
  logic [SW_W-1:0]                r_sw_sync;
  logic [SW_W-1:0]                r_sw_prev;
  logic [SW_W-1:0]                r_flag;
  logic [NUM_CH-1:0][ACC_W-1:0]   r_acc;
  logic [NUM_CH-1:0][ACC_W-1:0]   r_shadow;
  logic [NUM_CH-1:0][ACC_W-1:0]   r_active;
  logic [NUM_CH-1:0]              r_pend;
  logic [NUM_CH-1:0]              r_wrap;
  logic [31:0]                    r_rdata;
  logic                           r_rvalid;

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  logic                           w_wr_ctrl;
  logic                           w_wr_status;
  logic [NUM_CH-1:0]              w_wr_tune;
  logic [NUM_CH-1:0][ACC_W:0]     w_sum;
  logic [NUM_CH-1:0]              w_load;
  logic [SW_W-1:0]                w_sw_chg;
  logic [SW_W-1:0]                w_flag_clr;
  logic [31:0]                    w_status;
  logic [31:0]                    w_rd_data;
  logic                           w_unused_wdata;

  // Not every write-data bit maps to a register field for all parameter sets.
  assign w_unused_wdata = ^avs_s0_writedata;

  // Write-strobe decode for CTRL, STATUS and each TUNE register.
  always_comb begin
    w_wr_ctrl   = avs_s0_write && (avs_s0_address == {ADDR_W{1'b0}});
    w_wr_status = avs_s0_write && (avs_s0_address == ADDR_W'(1));
    w_wr_tune   = {NUM_CH{1'b0}};
    for (int ch = 0; ch < NUM_CH; ch++) begin
      w_wr_tune[ch] = avs_s0_write && (avs_s0_address == ADDR_W'(ch + 2));
    end
  end

  // Per-channel adder with carry-out, and the decision to move shadow into active.
  // An enabled channel only takes the new word on a carry, which keeps the
  // current period intact; a disabled one takes it straight away.
  always_comb begin
    w_sum  = {NUM_CH{{(ACC_W + 1){1'b0}}}};
    w_load = {NUM_CH{1'b0}};
    for (int ch = 0; ch < NUM_CH; ch++) begin
      w_sum[ch]  = {1'b0, r_acc[ch]} + {1'b0, r_active[ch]};
      w_load[ch] = r_pend[ch] && (!r_ctrl[ch] || w_sum[ch][ACC_W]);
    end
  end

  // Switch change detection and the write-1-to-clear mask.
  always_comb begin
    w_sw_chg   = r_sw_sync ^ r_sw_prev;
    w_flag_clr = w_wr_status ? avs_s0_writedata[16 +: SW_W] : {SW_W{1'b0}};
  end

  // Assemble STATUS and select the read data for the addressed register.
  always_comb begin
    w_status                = 32'd0;
    w_status[SW_W-1:0]      = r_sw_sync;
    w_status[16 +: SW_W]    = r_flag;
    w_status[24 +: NUM_CH]  = r_pend;
    w_rd_data               = 32'd0;
    case (avs_s0_address)
      ADDR_W'(0): w_rd_data = 32'(r_ctrl);
      ADDR_W'(1): w_rd_data = w_status;
      default: begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
          w_rd_data = w_rd_data |
                      ((avs_s0_address == ADDR_W'(ch + 2)) ? 32'(r_shadow[ch]) : 32'd0);
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------------

  // CTRL enable register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl <= {NUM_CH{1'b0}};
    end else if (w_wr_ctrl) begin
      r_ctrl <= avs_s0_writedata[NUM_CH-1:0];
    end
  end

  // Two-flop switch synchroniser, previous-sample register and sticky flags.
  // A new change event takes priority over a clear that arrives in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sw_meta <= {SW_W{1'b0}};
      r_sw_sync <= {SW_W{1'b0}};
      r_sw_prev <= {SW_W{1'b0}};
      r_flag    <= {SW_W{1'b0}};
    end else begin
      r_sw_meta <= sw;
      r_sw_sync <= r_sw_meta;
      r_sw_prev <= r_sw_sync;
      r_flag    <= (r_flag & ~w_flag_clr) | w_sw_chg;
    end
  end

  // Phase accumulators, tuning-word shadow and active registers, pending flags.
  // A disabled channel holds its accumulator at 0, so re-enabling it starts a
  // clean period. A TUNE write re-arms pending even in a cycle where an older
  // shadow value is being loaded, so the latest word is always the one applied.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc    <= {NUM_CH{{ACC_W{1'b0}}}};
      r_shadow <= {NUM_CH{{ACC_W{1'b0}}}};
      r_active <= {NUM_CH{{ACC_W{1'b0}}}};
      r_pend   <= {NUM_CH{1'b0}};
      r_wrap   <= {NUM_CH{1'b0}};
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (r_ctrl[ch]) begin
          r_acc[ch]  <= w_sum[ch][ACC_W-1:0];
          r_wrap[ch] <= w_sum[ch][ACC_W];
        end else begin
          r_acc[ch]  <= {ACC_W{1'b0}};
          r_wrap[ch] <= 1'b0;
        end
        if (w_load[ch]) begin
          r_active[ch] <= r_shadow[ch];
        end
        if (w_wr_tune[ch]) begin
          r_shadow[ch] <= avs_s0_writedata[ACC_W-1:0];
          r_pend[ch]   <= 1'b1;
        end else if (w_load[ch]) begin
          r_pend[ch]   <= 1'b0;
        end
      end
    end
  end

  // Read data register. The data is held between reads, and the valid bit
  // tracks the read strobe with one cycle of latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata  <= 32'd0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= avs_s0_read;
      if (avs_s0_read) begin
        r_rdata <= w_rd_data;
      end
    end
  end

  // Outputs: every one of them comes straight from a register.
  always_comb begin
    freq_out = {NUM_CH{1'b0}};
    for (int ch = 0; ch < NUM_CH; ch++) begin
      freq_out[ch] = r_acc[ch][ACC_W-1];
    end
  end

  assign wrap_pulse           = r_wrap;
  assign avs_s0_readdata      = r_rdata;
  assign avs_s0_readdatavalid = r_rvalid;

endmodule

// File: tb/tb_custom_freq_gen.sv
// -----------------------------------------------------------------------------
// tb_custom_freq_gen
//
// Directed bench for custom_freq_gen with default parameters
// (4 channels, 32-bit accumulators, 4 switches, 4-bit address).
// Inputs are driven on the falling edge and outputs are sampled there too,
// half a cycle after the rising edge that updated them.
// -----------------------------------------------------------------------------
module tb_custom_freq_gen;

  logic        clk;
  logic        reset;
  logic [3:0]  avs_s0_address;
  logic        avs_s0_read;
  logic        avs_s0_write;
  logic [31:0] avs_s0_writedata;
  logic [31:0] avs_s0_readdata;
  logic        avs_s0_readdatavalid;
  logic [3:0]  sw;
  logic [3:0]  freq_out;
  logic [3:0]  wrap_pulse;

  int checks = 0;
  int errors = 0;

  custom_freq_gen #(
    .NUM_CH (4),
    .ACC_W  (32),
    .SW_W   (4),
    .ADDR_W (4)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .avs_s0_address       (avs_s0_address),
    .avs_s0_read          (avs_s0_read),
    .avs_s0_write         (avs_s0_write),
    .avs_s0_writedata     (avs_s0_writedata),
    .avs_s0_readdata      (avs_s0_readdata),
    .avs_s0_readdatavalid (avs_s0_readdatavalid),
    .sw                   (sw),
    .freq_out             (freq_out),
    .wrap_pulse           (wrap_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic avs_wr(input logic [3:0] a, input logic [31:0] d);
    avs_s0_address   = a;
    avs_s0_writedata = d;
    avs_s0_write     = 1'b1;
    @(negedge clk);
    avs_s0_write     = 1'b0;
  endtask

  // Called at a falling edge. Issues one read, then checks valid and data.
  task automatic avs_rd(input logic [3:0] a, input logic [31:0] exp, input string tag);
    avs_s0_address = a;
    avs_s0_read    = 1'b1;
    @(negedge clk);
    avs_s0_read    = 1'b0;
    chk({tag, "_valid"}, 32'(avs_s0_readdatavalid), 32'd1);
    chk(tag, avs_s0_readdata, exp);
  endtask

  logic [7:0]  f2_exp;
  logic [7:0]  w2_exp;
  logic [15:0] f3_exp;
  logic [15:0] w3_exp;

  initial begin
    reset            = 1'b1;
    avs_s0_address   = 4'd0;
    avs_s0_read      = 1'b0;
    avs_s0_write     = 1'b0;
    avs_s0_writedata = 32'd0;
    sw               = 4'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state and the first reads.
    chk("rst_valid", 32'(avs_s0_readdatavalid), 32'd0);
    chk("rst_rdata", avs_s0_readdata, 32'd0);
    chk("rst_freq", 32'(freq_out), 32'd0);
    chk("rst_wrap", 32'(wrap_pulse), 32'd0);
    avs_rd(4'd0, 32'd0, "rst_ctrl");
    avs_rd(4'd1, 32'd0, "rst_status");
    avs_rd(4'd2, 32'd0, "rst_tune0");

    // Channel 0, tune 0x4000_0000: period of 4 clocks.
    avs_wr(4'd2, 32'h4000_0000);
    avs_wr(4'd0, 32'h0000_0001);
    f2_exp = 8'b1100_1100;
    w2_exp = 8'b0001_0000;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("p4_freq%0d", i), 32'(freq_out), {28'd0, 3'd0, f2_exp[i]});
      chk($sformatf("p4_wrap%0d", i), 32'(wrap_pulse), {28'd0, 3'd0, w2_exp[i]});
      @(negedge clk);
    end

    // Retune mid-period: pending until the next wrap, then period of 8.
    avs_wr(4'd2, 32'h2000_0000);
    avs_rd(4'd1, 32'h0100_0000, "pend_set");
    f3_exp = 16'hC3C3;
    w3_exp = 16'h0404;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("p8_freq%0d", i), 32'(freq_out), {28'd0, 3'd0, f3_exp[i]});
      chk($sformatf("p8_wrap%0d", i), 32'(wrap_pulse), {28'd0, 3'd0, w3_exp[i]});
      @(negedge clk);
    end
    avs_rd(4'd1, 32'h0000_0000, "pend_clr");

    // Switch synchroniser latency, sticky flag, and write-1-to-clear.
    sw = 4'b0100;
    @(negedge clk);
    avs_rd(4'd1, 32'h0000_0000, "sw_lat1");
    avs_rd(4'd1, 32'h0000_0004, "sw_lat2");
    avs_rd(4'd1, 32'h0004_0004, "sw_flag");
    avs_wr(4'd1, 32'h0004_0000);
    avs_rd(4'd1, 32'h0000_0004, "sw_w1c");
    // A set event in the same cycle as the clear wins.
    sw = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    avs_wr(4'd1, 32'h0004_0000);
    avs_rd(4'd1, 32'h0004_0000, "sw_setwins");

    // A simultaneous read and write returns the data from before the write.
    avs_s0_address   = 4'd3;
    avs_s0_writedata = 32'h0000_1234;
    avs_s0_write     = 1'b1;
    avs_s0_read      = 1'b1;
    @(negedge clk);
    avs_s0_write = 1'b0;
    avs_s0_read  = 1'b0;
    chk("rw_valid", 32'(avs_s0_readdatavalid), 32'd1);
    chk("rw_old", avs_s0_readdata, 32'd0);
    avs_rd(4'd3, 32'h0000_1234, "rw_new");

    // Unmapped address, then registers unchanged; read data is held when idle.
    avs_wr(4'd15, 32'hFFFF_FFFF);
    avs_rd(4'd15, 32'd0, "unmap_rd");
    avs_rd(4'd0, 32'h0000_0001, "unmap_ctrl");
    @(negedge clk);
    chk("idle_valid", 32'(avs_s0_readdatavalid), 32'd0);
    chk("idle_hold", avs_s0_readdata, 32'h0000_0001);
    avs_rd(4'd2, 32'h2000_0000, "unmap_tune0");

    // Reset while all four channels run.
    avs_wr(4'd3, 32'h8000_0000);
    avs_wr(4'd4, 32'h1000_0000);
    avs_wr(4'd5, 32'h4000_0000);
    avs_wr(4'd0, 32'h0000_000F);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mrst_freq", 32'(freq_out), 32'd0);
    chk("mrst_wrap", 32'(wrap_pulse), 32'd0);
    chk("mrst_valid", 32'(avs_s0_readdatavalid), 32'd0);
    chk("mrst_rdata", avs_s0_readdata, 32'd0);
    reset = 1'b0;
    avs_rd(4'd0, 32'd0, "mrst_ctrl");
    avs_rd(4'd1, 32'd0, "mrst_status");
    avs_rd(4'd2, 32'd0, "mrst_tune0");
    avs_rd(4'd3, 32'd0, "mrst_tune1");
    avs_rd(4'd4, 32'd0, "mrst_tune2");
    avs_rd(4'd5, 32'd0, "mrst_tune3");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
